// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with a start/ready handshake.
// A request pulse is latched while idle. The sub-word read or write then runs
// after LATENCY cycles, and ready pulses together with the load data and the err flag.
// The access-type port is named acc_type because "type" is a SystemVerilog keyword.
module dm_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  acc_type,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic [31:0] pc,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rd,
   output logic        err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   logic [3:0]  cnt;

   // latched request
   logic        we_q;
   logic [2:0]  type_q;
   logic [31:0] addr_q;
   logic [31:0] wd_q;
   logic [31:0] pc_q;

   logic [31:0] mem [DEPTH];

   // operands of the access being executed this cycle
   logic                  accept;
   logic                  exec_now;
   logic                  op_we;
   logic [2:0]            op_type;
   logic [31:0]           op_addr;
   logic [31:0]           op_wd;
   logic [31:0]           op_pc;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           cur;
   logic                  illegal;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [31:0]           load_v;
   logic [31:0]           merged;
   logic [31:0]           lane_mask;
   logic [31:0]           lane_data;
   logic [31:0]           rd_next;
   logic                  commit;

   assign busy   = (state != IDLE);
   assign accept = (state == IDLE) && req;

   // Select live inputs when the access runs on the accepting edge (LATENCY=1),
   // otherwise the latched copies; then decode legality, lanes, load and merge.
   always_comb begin
      op_we   = we_q;
      op_type = type_q;
      op_addr = addr_q;
      op_wd   = wd_q;
      op_pc   = pc_q;
      if (state == IDLE) begin
         op_we   = we;
         op_type = acc_type;
         op_addr = addr;
         op_wd   = wd;
         op_pc   = pc;
      end

      exec_now = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));

      idx = op_addr[ADDR_WIDTH+1:2];
      cur = mem[idx];

      illegal = (op_type > 3'd4)
             || ((op_type == 3'd0) && (op_addr[1:0] != 2'b00))
             || (((op_type == 3'd1) || (op_type == 3'd2)) && op_addr[0]);

      byte_v = 8'(cur >> {op_addr[1:0], 3'b000});
      half_v = 16'(cur >> {op_addr[1], 4'b0000});

      case (op_type)
         3'd0:    load_v = cur;
         3'd1:    load_v = {16'b0, half_v};
         3'd2:    load_v = {{16{half_v[15]}}, half_v};
         3'd3:    load_v = {24'b0, byte_v};
         3'd4:    load_v = {{24{byte_v[7]}}, byte_v};
         default: load_v = 32'b0;
      endcase

      case (op_type)
         3'd1, 3'd2: begin
            lane_mask = 32'h0000_FFFF << {op_addr[1], 4'b0000};
            lane_data = {16'b0, op_wd[15:0]} << {op_addr[1], 4'b0000};
         end
         3'd3, 3'd4: begin
            lane_mask = 32'h0000_00FF << {op_addr[1:0], 3'b000};
            lane_data = {24'b0, op_wd[7:0]} << {op_addr[1:0], 3'b000};
         end
         default: begin
            lane_mask = 32'hFFFF_FFFF;
            lane_data = op_wd;
         end
      endcase
      merged = (cur & ~lane_mask) | (lane_data & lane_mask);

      rd_next = (illegal || op_we) ? 32'b0 : load_v;
      commit  = exec_now && op_we && !illegal;
   end

   // Control FSM with registered ready/rd/err outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         ready <= 1'b0;
         rd    <= 32'b0;
         err   <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  cnt <= 4'(LATENCY - 1);
                  if (LATENCY > 1) begin
                     state <= WAIT;
                  end else begin
                     state <= RESP;
                     ready <= 1'b1;
                     rd    <= rd_next;
                     err   <= illegal;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
                  ready <= 1'b1;
                  rd    <= rd_next;
                  err   <= illegal;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Capture the request so later input changes do not disturb it
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q   <= we;
         type_q <= acc_type;
         addr_q <= addr;
         wd_q   <= wd;
         pc_q   <= pc;
      end
   end

   // Memory array: cleared on reset, read-modify-write on commit
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'b0;
         end
      end else if (commit) begin
         mem[idx] <= merged;
      end
   end

`ifndef SYNTHESIS
   // Write log, one line per committed store
   always_ff @(posedge clk) begin
      if (!reset && commit) begin
         $display("@%h: *%h <= %h", op_pc, {op_addr[31:2], 2'b00}, merged);
      end
   end
`endif

endmodule
